// File: rtl/dpram_fifo_pkg.sv
// Shared constants and types for the dpram_1024x8 FIFO controller.
package dpram_fifo_pkg;

    localparam int unsigned DW           = 8;
    localparam int unsigned AW           = 10;
    localparam int unsigned DEPTH        = 1 << AW;
    localparam int unsigned AFULL_TH_DEF = 1000;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;
    typedef logic [DW-1:0] data_t;

endpackage : dpram_fifo_pkg

// File: rtl/dpram_fifo_skid_buf.sv
// Two-entry output buffer that absorbs the RAM's one-cycle read latency.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   wr_en      : capture wr_data at the end of this cycle
//   wr_data    : word returned by the RAM
//   rd_en      : drop the head entry (caller guarantees cnt != 0)
//   rd_data    : head entry
//   cnt        : number of entries held (0..2)
module dpram_fifo_skid_buf
    import dpram_fifo_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  data_t      wr_data,
    input  logic       rd_en,
    output data_t      rd_data,
    output logic [1:0] cnt
);

    data_t mem [2];
    logic  wr_ptr;
    logic  rd_ptr;

    // Storage needs no reset; cnt qualifies every entry.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous write and read keep order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (wr_en) begin
                wr_ptr <= ~wr_ptr;
            end
            if (rd_en) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt <= cnt + 2'(wr_en) - 2'(rd_en);
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule : dpram_fifo_skid_buf

// File: rtl/dpram_fifo_ctrl.sv
// Streaming FIFO controller in front of the dpram_1024x8 primitive.
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   in_valid/in_ready/in_data    : write-side stream
//   out_valid/out_ready/out_data : read-side stream (head of output buffer)
//   level, almost_full  : registered occupancy (RAM + in-flight + buffer)
//   ram_*               : direct connection to the RAM ports
module dpram_fifo_ctrl
    import dpram_fifo_pkg::*;
#(
    parameter int unsigned AFULL_TH = AFULL_TH_DEF
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  in_valid,
    output logic  in_ready,
    input  data_t in_data,
    output logic  out_valid,
    input  logic  out_ready,
    output data_t out_data,
    output cnt_t  level,
    output logic  almost_full,
    output ptr_t  ram_waddr,
    output ptr_t  ram_raddr,
    output data_t ram_data_in,
    output logic  ram_wen,
    output logic  ram_ren,
    input  data_t ram_data_out
);

    ptr_t       wptr;
    ptr_t       rptr;
    cnt_t       ram_cnt;
    logic       inflight;
    logic [1:0] buf_cnt;

    logic       full;
    logic       push;
    logic       pop;
    logic       ren_issue;
    logic [2:0] buf_occ;
    cnt_t       ram_cnt_nxt;
    logic [1:0] buf_cnt_nxt;
    cnt_t       level_nxt;

    // Handshakes, read issue and next-state occupancy.
    always_comb begin
        full        = (ram_cnt == cnt_t'(DEPTH));
        in_ready    = !full && !reset;
        push        = in_valid && in_ready;
        pop         = out_valid && out_ready;
        // Buffer slots already promised after this cycle's pop.
        buf_occ     = 3'(buf_cnt) + 3'(inflight) - 3'(pop);
        // Uses the pre-update count, so a word is never read in its write cycle.
        ren_issue   = !reset && (ram_cnt != '0) && (buf_occ < 3'd2);
        ram_cnt_nxt = ram_cnt + cnt_t'(push) - cnt_t'(ren_issue);
        buf_cnt_nxt = buf_cnt + 2'(inflight) - 2'(pop);
        level_nxt   = ram_cnt_nxt + cnt_t'(ren_issue) + cnt_t'(buf_cnt_nxt);
    end

    assign ram_wen     = push;
    assign ram_waddr   = wptr;
    assign ram_data_in = in_data;
    assign ram_ren     = ren_issue;
    assign ram_raddr   = rptr;

    // Pointers, counters and registered status.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr        <= '0;
            rptr        <= '0;
            ram_cnt     <= '0;
            inflight    <= 1'b0;
            level       <= '0;
            almost_full <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + ptr_t'(1);
            end
            if (ren_issue) begin
                rptr <= rptr + ptr_t'(1);
            end
            ram_cnt     <= ram_cnt_nxt;
            inflight    <= ren_issue;
            level       <= level_nxt;
            almost_full <= (level_nxt >= cnt_t'(AFULL_TH));
        end
    end

    // RAM data is valid the cycle after issue; reset clears inflight so a stale result is dropped.
    dpram_fifo_skid_buf u_skid_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (inflight),
        .wr_data (ram_data_out),
        .rd_en   (pop),
        .rd_data (out_data),
        .cnt     (buf_cnt)
    );

    assign out_valid = (buf_cnt != 2'd0);

endmodule : dpram_fifo_ctrl

// File: tb/tb_dpram_fifo_ctrl.sv
// Randomised + directed bench for dpram_fifo_ctrl with a queue-based reference model.
module tb_dpram_fifo_ctrl;
    import dpram_fifo_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [10:0] level;
    logic        almost_full;
    logic [9:0]  ram_waddr;
    logic [9:0]  ram_raddr;
    logic [7:0]  ram_data_in;
    logic        ram_wen;
    logic        ram_ren;
    logic [7:0]  ram_data_out;

    always #5 clk = ~clk;

    // Behavioural dpram_1024x8: registered read, data valid the cycle after ren.
    logic [7:0] mem [1024];
    always @(posedge clk) begin
        if (ram_wen) mem[ram_waddr] <= ram_data_in;
        if (ram_ren) ram_data_out <= mem[ram_raddr];
    end

    dpram_fifo_ctrl #(.AFULL_TH(1000)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .level        (level),
        .almost_full  (almost_full),
        .ram_waddr    (ram_waddr),
        .ram_raddr    (ram_raddr),
        .ram_data_in  (ram_data_in),
        .ram_wen      (ram_wen),
        .ram_ren      (ram_ren),
        .ram_data_out (ram_data_out)
    );

    localparam int SEL_WEN   = 0;
    localparam int SEL_WADDR = 1;
    localparam int SEL_REN   = 2;
    localparam int SEL_RADDR = 3;
    localparam int SEL_OV    = 4;
    localparam int SEL_OD    = 5;
    localparam int SEL_LEVEL = 6;
    localparam int SEL_IRDY  = 7;
    localparam int SEL_AF    = 8;
    localparam int SEL_RAW   = 9;

    int          n_pass  = 0;
    int          n_total = 0;
    int          cyc     = 0;
    bit          chk_en  = 1'b0;

    // Literal expectations posted by the stimulus, consumed at the next falling edge.
    string       x_name [1024];
    int          x_sel  [1024];
    logic [31:0] x_val  [1024];
    logic [31:0] x_act  [1024];
    int          x_wr = 0;
    int          x_rd = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] sig_val(input int sel);
        case (sel)
            SEL_WEN:   return 32'(ram_wen);
            SEL_WADDR: return 32'(ram_waddr);
            SEL_REN:   return 32'(ram_ren);
            SEL_RADDR: return 32'(ram_raddr);
            SEL_OV:    return 32'(out_valid);
            SEL_OD:    return 32'(out_data);
            SEL_LEVEL: return 32'(level);
            SEL_IRDY:  return 32'(in_ready);
            SEL_AF:    return 32'(almost_full);
            default:   return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Reference model: three data queues for RAM contents, in-flight read, output buffer.
    logic [7:0]  ram_q [$];
    logic [7:0]  fl_q  [$];
    logic [7:0]  bf_q  [$];
    int unsigned wcnt = 0;
    int unsigned rcnt = 0;

    // Single compare process: model check every cycle, then posted literal checks.
    always @(negedge clk) begin
        int   rsz;
        int   fsz;
        int   bsz;
        int   lvl;
        logic e_rdy;
        logic e_push;
        logic e_pop;
        logic e_iss;
        if (chk_en) begin
            rsz    = ram_q.size();
            fsz    = fl_q.size();
            bsz    = bf_q.size();
            lvl    = rsz + fsz + bsz;
            e_rdy  = !reset && (rsz < 1024);
            e_push = in_valid && e_rdy;
            e_pop  = (bsz > 0) && out_ready;
            e_iss  = !reset && (rsz > 0) && ((bsz + fsz - (e_pop ? 1 : 0)) < 2);
            check("in_ready", 32'(in_ready), 32'(e_rdy));
            check("ram_wen", 32'(ram_wen), 32'(e_push));
            check("ram_ren", 32'(ram_ren), 32'(e_iss));
            check("out_valid", 32'(out_valid), 32'(bsz > 0));
            check("level", 32'(level), 32'(lvl));
            check("almost_full", 32'(almost_full), 32'(lvl >= 1000));
            if (e_push) begin
                check("ram_waddr", 32'(ram_waddr), 32'(wcnt % 1024));
                check("ram_data_in", 32'(ram_data_in), 32'(in_data));
            end
            if (e_iss) check("ram_raddr", 32'(ram_raddr), 32'(rcnt % 1024));
            if (bsz > 0) check("out_data", 32'(out_data), 32'(bf_q[0]));
            if (reset) begin
                ram_q.delete(); fl_q.delete(); bf_q.delete();
                wcnt = 0; rcnt = 0;
            end else begin
                if (e_pop) void'(bf_q.pop_front());
                if (fsz > 0) bf_q.push_back(fl_q.pop_front());
                if (e_iss) begin
                    fl_q.push_back(ram_q.pop_front());
                    rcnt++;
                end
                if (e_push) begin
                    ram_q.push_back(in_data);
                    wcnt++;
                end
            end
        end
        while (x_rd < x_wr) begin
            check(x_name[x_rd], (x_sel[x_rd] == SEL_RAW) ? x_act[x_rd] : sig_val(x_sel[x_rd]), x_val[x_rd]);
            x_rd++;
        end
    end

    task automatic post(input int sel, input logic [31:0] val, input string name);
        if (x_wr < 1024) begin
            x_name[x_wr] = name; x_sel[x_wr] = sel; x_val[x_wr] = val; x_act[x_wr] = '0;
            x_wr++;
        end
    endtask

    task automatic post_raw(input logic [31:0] act, input logic [31:0] val, input string name);
        if (x_wr < 1024) begin
            x_name[x_wr] = name; x_sel[x_wr] = SEL_RAW; x_val[x_wr] = val; x_act[x_wr] = act;
            x_wr++;
        end
    endtask

    int pushed  = 0;
    int last_w  = -1;
    int last_r  = -1;
    bit w_wrap  = 1'b0;
    bit r_wrap  = 1'b0;

    // One cycle: bookkeeping at the falling edge, then advance to just after the next rising edge.
    task automatic step();
        @(negedge clk);
        if (in_valid && in_ready) pushed++;
        if (ram_wen) begin
            if (last_w == 1023 && ram_waddr == 10'd0) w_wrap = 1'b1;
            last_w = int'(ram_waddr);
        end
        if (ram_ren) begin
            if (last_r == 1023 && ram_raddr == 10'd0) r_wrap = 1'b1;
            last_r = int'(ram_raddr);
        end
        @(posedge clk);
        #1;
    endtask

    logic [7:0] fill_first;
    logic [7:0] bp [5];
    int         budget;

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
        @(posedge clk); #1;
        chk_en = 1'b1;
        post(SEL_LEVEL, 0, "reset_level");
        post(SEL_OV, 0, "reset_out_valid");
        post(SEL_IRDY, 0, "reset_in_ready");
        step();
        reset = 1'b0;

        // Single word from empty.
        in_valid = 1'b1; in_data = 8'hA5;
        post(SEL_WEN, 1, "t1_wen"); post(SEL_WADDR, 0, "t1_waddr"); post(SEL_LEVEL, 0, "t1_level0");
        step();
        in_valid = 1'b0;
        post(SEL_REN, 1, "t1_ren"); post(SEL_RADDR, 0, "t1_raddr"); post(SEL_LEVEL, 1, "t1_level1");
        step();
        post(SEL_OV, 0, "t1_not_yet_valid");
        step();
        post(SEL_OV, 1, "t1_out_valid"); post(SEL_OD, 32'hA5, "t1_out_data");
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        post(SEL_LEVEL, 0, "t1_level_after_pop"); post(SEL_OV, 0, "t1_empty");
        step();

        // Streaming 0x00..0xFF: word i appears at cycle i+3, no gaps.
        for (int c = 0; c < 260; c++) begin
            in_valid  = (c < 256);
            in_data   = 8'(c);
            out_ready = 1'b1;
            if (c >= 3 && c < 259) begin
                post(SEL_OV, 1, "stream_valid");
                post(SEL_OD, 32'(c - 3), "stream_data");
            end
            if (c == 259) post(SEL_OV, 0, "stream_done");
            step();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        step();

        // Fill to full with the reader stalled.
        for (int c = 0; c < 1030; c++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            if (c == 0) fill_first = in_data;
            if (c == 999) begin post(SEL_LEVEL, 999, "fill_level999"); post(SEL_AF, 0, "fill_af_below"); end
            if (c == 1000) begin post(SEL_LEVEL, 1000, "fill_level1000"); post(SEL_AF, 1, "fill_af_at"); end
            step();
        end
        post(SEL_LEVEL, 1026, "full_level"); post(SEL_IRDY, 0, "full_in_ready");
        post(SEL_AF, 1, "full_af"); post(SEL_OD, 32'(fill_first), "full_head");
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        post(SEL_IRDY, 1, "full_ready_after_pop"); post(SEL_LEVEL, 1025, "full_level_after_pop");
        step();
        out_ready = 1'b1;
        for (int c = 0; c < 1040; c++) step();
        out_ready = 1'b0;
        post(SEL_LEVEL, 0, "drain_level"); post(SEL_OV, 0, "drain_empty");
        step();

        // Backpressure: head must hold and no further reads issue while stalled.
        for (int i = 0; i < 5; i++) bp[i] = 8'($urandom);
        for (int c = 0; c < 8; c++) begin
            in_valid = (c < 5);
            in_data  = (c < 5) ? bp[c] : 8'h00;
            if (c >= 3) begin
                post(SEL_OV, 1, "bp_valid"); post(SEL_OD, 32'(bp[0]), "bp_hold"); post(SEL_REN, 0, "bp_no_ren");
            end
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 12; c++) step();
        out_ready = 1'b0;

        // Reset while a RAM read is in flight with level 10.
        for (int c = 0; c < 13; c++) begin
            in_valid = (c < 10); in_data = 8'($urandom);
            step();
        end
        in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
        post(SEL_REN, 1, "rst_pre_ren"); post(SEL_LEVEL, 10, "rst_pre_level");
        step();
        in_valid = 1'b0; out_ready = 1'b0; reset = 1'b1;
        post(SEL_LEVEL, 10, "rst_inflight_level");
        step();
        reset = 1'b0;
        post(SEL_LEVEL, 0, "rst_level"); post(SEL_OV, 0, "rst_out_valid");
        in_valid = 1'b1; in_data = 8'h3C;
        post(SEL_WEN, 1, "rst_wen"); post(SEL_WADDR, 0, "rst_waddr");
        step();
        in_valid = 1'b0;
        post(SEL_REN, 1, "rst_ren"); post(SEL_RADDR, 0, "rst_raddr");
        step();
        step();
        post(SEL_OV, 1, "rst_3c_valid"); post(SEL_OD, 32'h3C, "rst_3c_data");
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Random traffic: 3000 pushes with pointer wrap.
        pushed = 0; w_wrap = 1'b0; r_wrap = 1'b0; budget = 0;
        while (pushed < 3000 && budget < 20000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            step();
            budget++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 1100; c++) step();
        post_raw(32'(pushed >= 3000), 1, "rand_push_budget");
        post_raw(32'(w_wrap), 1, "rand_waddr_wrap");
        post_raw(32'(r_wrap), 1, "rand_raddr_wrap");
        post(SEL_LEVEL, 0, "rand_drained");
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_dpram_fifo_ctrl

// File: doc/dpram_fifo_ctrl.md
Name: dpram_fifo_ctrl

Overview:
- FIFO controller placed directly upstream of the dpram_1024x8 primitive in the memory logical tile.
- Drives the RAM's waddr/raddr/data_in/wen/ren and consumes its data_out.
- Presents a valid/ready streaming FIFO on both sides.
- Hides the RAM's 1-cycle synchronous read latency with a 2-entry output buffer, so the read side sustains 1 word/cycle.

Parameters:
- DW, 8, data width; must match the RAM data width.
- AW, 10, address width; RAM depth is 2**AW = 1024.
- AFULL_TH, 1000, almost_full asserts when level >= AFULL_TH.

Ports:
- clk  input  1  single clock for the block and the RAM.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  write-side data valid.
- in_ready  output  1  write-side ready; equals !full and !reset.
- in_data  input  DW  write-side data.
- out_valid  output  1  read-side data valid; the head of the output buffer.
- out_ready  input  1  read-side consumer ready.
- out_data  output  DW  read-side data; the head of the output buffer.
- level  output  AW+1  total words held: ram_cnt + inflight + buf_cnt, maximum 1026.
- almost_full  output  1  level >= AFULL_TH.
- ram_waddr  output  AW  to RAM waddr.
- ram_raddr  output  AW  to RAM raddr.
- ram_data_in  output  DW  to RAM data_in.
- ram_wen  output  1  to RAM wen.
- ram_ren  output  1  to RAM ren.
- ram_data_out  input  DW  from RAM data_out; valid 1 cycle after ram_ren.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - wptr, rptr, ram_cnt, inflight and buf_cnt all clear to 0.
  - Outputs: out_valid=0, level=0, almost_full=0, in_ready=0.
  - ram_wen=0 and ram_ren=0 while reset is high.
  - Reset mid-operation discards all contents; an in-flight RAM read result is ignored.
- push = in_valid & in_ready.
  - ram_wen = push; ram_waddr = wptr; ram_data_in = in_data.
  - On push, wptr increments mod 2**AW, with natural wrap from 1023 to 0.
- full = (ram_cnt == 2**AW); ram_cnt counts words written to the RAM and not yet read from it.
- Read issue:
  - ren_issue = (ram_cnt != 0) & ((buf_cnt + inflight - pop) < 2), where pop = out_valid & out_ready.
  - ram_ren = ren_issue; ram_raddr = rptr.
  - On issue, rptr increments mod 2**AW and inflight is set for the next cycle.
- Capture: when inflight=1, ram_data_out is written into the output buffer at the end of that cycle.
- ram_cnt next value = ram_cnt + push - ren_issue.
  - Push and read issue may occur in the same cycle.
  - The count saturates at neither end, because the guards make overflow and underflow impossible.
- Same-address hazard is impossible:
  - A read issues only when ram_cnt != 0 using the pre-update count.
  - A word written in cycle N is therefore first readable in cycle N+1.
- Latency from empty:
  - push in cycle N, ren in N+1, RAM output valid in N+2, out_valid=1 in N+3.
  - level counts the word from N+1.
- Output buffer:
  - 2-entry FIFO of DW bits; out_valid = (buf_cnt != 0).
  - Capture and pop in the same cycle are allowed; order is preserved.
  - out_data must hold stable while out_valid=1 and out_ready=0.
- Throughput: continuous push and pop sustain 1 word/cycle with no bubbles after the initial latency.
- Full:
  - in_ready=0 whenever ram_cnt == 1024.
  - A read issued in the same cycle frees a slot for the next cycle only; there is no same-cycle bypass.
- Empty: out_valid=0; ram_ren=0 when ram_cnt == 0.
- Registered outputs: level and almost_full are registered from the next-state values and are updated every cycle.

Decomposition:
- Shared package dpram_fifo_pkg:
  - DW, AW, DEPTH constants.
  - Pointer type logic [AW-1:0].
  - Count type logic [AW:0].
- One sub-module: dpram_fifo_skid_buf.
  - 2-entry output buffer with ports wr_en, wr_data, rd_en, rd_data, cnt.
  - The top-level block holds the pointers, counters and issue logic.

Test Plan:
- Reset then single word:
  - Stimulus: push 0xA5 at cycle 0.
  - Required: ram_wen=1 with ram_waddr=0 in cycle 0; ram_ren=1 with ram_raddr=0 in cycle 1; out_valid=1 and out_data=0xA5 in cycle 3; level goes 0→1.
- Streaming:
  - Stimulus: push 0x00..0xFF back-to-back with out_ready held at 1.
  - Required: out_data emits 0x00..0xFF in order on consecutive cycles, with no gaps after the first 3-cycle latency.
- Fill to full:
  - Stimulus: push 1026 words with out_ready=0.
  - Required: buffer holds 2 words; ram_cnt reaches 1024; in_ready=0; level=1026; almost_full=1 from level 1000.
  - Then: a single pop raises in_ready in the next cycle.
- Wrap-around:
  - Stimulus: 3000 words with random in_valid/out_ready.
  - Required: ram_waddr and ram_raddr wrap from 1023 to 0; the data sequence is intact; no RAM read of an unwritten address.
- Backpressure stability:
  - Stimulus: out_ready=0 for 5 cycles with out_valid=1.
  - Required: out_data stays stable; at most 1 extra read issues to fill buffer entry 2, then ram_ren=0.
- Reset mid-stream:
  - Stimulus: assert reset for 1 cycle while inflight=1 and level=10.
  - Required: next cycle level=0, out_valid=0; a subsequent push of 0x3C is read from address 0 and emerges correctly.
